// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
//
// Builds a 3x3 pixel window from the live pixel stream and the two
// line-delayed streams produced by the upstream line buffers. It tracks the
// frame position of every accepted pixel and flags only windows that lie
// fully inside the frame. There is no edge padding.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   data_en      pixel strobe; row*_in are sampled when high
//   frame_start  together with data_en, marks the pixel as (row 0, col 0)
//   row0_in      current-line pixel (bottom row of the window)
//   row1_in      one-line-delayed pixel (middle row of the window)
//   row2_in      two-line-delayed pixel (top row of the window)
//   win_out      window; p(r,c) at [DATA_W*(3*r+c) +: DATA_W],
//                r=0 is the top row, c=0 is the left (oldest) column
//   win_valid    win_out holds a complete in-frame window
//   ctr_col      column of the window centre pixel
//   ctr_row      row of the window centre pixel
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 720
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_en,
  input  logic                      frame_start,
  input  logic [DATA_W-1:0]         row0_in,
  input  logic [DATA_W-1:0]         row1_in,
  input  logic [DATA_W-1:0]         row2_in,
  output logic [9*DATA_W-1:0]       win_out,
  output logic                      win_valid,
  output logic [$clog2(IMG_W)-1:0]  ctr_col,
  output logic [$clog2(IMG_H)-1:0]  ctr_row,
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // Position of the pixel currently presented on the inputs.
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          col_last;
  logic          row_last;
  logic          in_frame;

  // Incoming pixel per window row: the oldest line feeds the top row.
  logic [DATA_W-1:0] new_pix [3];

  assign new_pix[0] = row2_in;
  assign new_pix[1] = row1_in;
  assign new_pix[2] = row0_in;

  // frame_start forces the presented pixel to (0,0), abandoning whatever
  // frame the counters were tracking.
  always_comb begin
    cur_col  = col_cnt;
    cur_row  = row_cnt;
    if (frame_start) begin
      cur_col = '0;
      cur_row = '0;
    end
    col_last = (cur_col == COL_LAST);
    row_last = (cur_row == ROW_LAST);
    // Columns 0 and 1 of each line still hold pixels of the previous line
    // in the left taps, so they never form a window.
    in_frame = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  end

  // The shift registers are the window itself, so win_out updates on the
  // same edge that accepts the pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_out    <= '0;
      win_valid  <= 1'b0;
      ctr_col    <= '0;
      ctr_row    <= '0;
      frame_done <= 1'b0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (data_en) begin
        for (int r = 0; r < 3; r++) begin
          win_out[DATA_W*(3*r+0) +: DATA_W] <= win_out[DATA_W*(3*r+1) +: DATA_W];
          win_out[DATA_W*(3*r+1) +: DATA_W] <= win_out[DATA_W*(3*r+2) +: DATA_W];
          win_out[DATA_W*(3*r+2) +: DATA_W] <= new_pix[r];
        end

        win_valid <= in_frame;
        // Centre is one column left and one line up from the newest pixel;
        // the centre coordinates hold while no window is flagged.
        if (in_frame) begin
          ctr_col <= cur_col - CW'(1);
          ctr_row <= cur_row - RW'(1);
        end

        if (col_last) begin
          col_cnt <= '0;
          if (row_last) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= cur_row + RW'(1);
          end
        end else begin
          col_cnt <= cur_col + CW'(1);
          row_cnt <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;

  logic        clk;
  logic        rst;
  logic        data_en;
  logic        frame_start;
  logic [7:0]  row0_in;
  logic [7:0]  row1_in;
  logic [7:0]  row2_in;
  logic [71:0] win_out;
  logic        win_valid;
  logic [2:0]  ctr_col;
  logic [2:0]  ctr_row;
  logic        frame_done;

  window_3x3_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_en     (data_en),
    .frame_start (frame_start),
    .row0_in     (row0_in),
    .row1_in     (row1_in),
    .row2_in     (row2_in),
    .win_out     (win_out),
    .win_valid   (win_valid),
    .ctr_col     (ctr_col),
    .ctr_row     (ctr_row),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic [2:0]  col;
    logic [2:0]  row;
  } exp_t;

  exp_t exp_q[$];
  bit   done_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int n_valid = 0;
  int n_done = 0;

  // Driver-side frame position and the index of the pixel on the inputs.
  int mc = 0;
  int mr = 0;
  int cur_idx = 0;

  // Per-pixel record of what the DUT presented after accepting that pixel.
  logic        vlog [48];
  logic [2:0]  clog [48];
  logic [2:0]  rlog [48];
  logic [71:0] wlog [48];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    if (r < 0 || c < 0) return 8'h00;
    return 8'((8 * r + c) % 256);
  endfunction

  function automatic logic [71:0] win_of(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[8*(3*rr+cc) +: 8] = pix(r - 2 + rr, c - 2 + cc);
    return w;
  endfunction

  task automatic drive_pix(input bit en, input bit fs);
    exp_t e;
    @(negedge clk);
    rst         = 1'b1;
    data_en     = en;
    frame_start = fs & en;
    if (en) begin
      if (fs) begin
        mc = 0;
        mr = 0;
      end
      row0_in = pix(mr, mc);
      row1_in = pix(mr - 1, mc);
      row2_in = pix(mr - 2, mc);
      cur_idx = 8 * mr + mc;
      if (mc >= 2 && mr >= 2) begin
        e.win = win_of(mr, mc);
        e.col = 3'(mc - 1);
        e.row = 3'(mr - 1);
        exp_q.push_back(e);
      end
      if (mc == IMG_W - 1 && mr == IMG_H - 1) begin
        done_q.push_back(1'b1);
        mc = 0;
        mr = 0;
      end else if (mc == IMG_W - 1) begin
        mc = 0;
        mr++;
      end else begin
        mc++;
      end
    end else begin
      row0_in = 8'($urandom);
      row1_in = 8'($urandom);
      row2_in = 8'($urandom);
    end
  endtask

  task automatic drive_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst         = 1'b0;
      data_en     = 1'b1;
      frame_start = 1'b0;
      row0_in     = 8'($urandom);
      row1_in     = 8'($urandom);
      row2_in     = 8'($urandom);
    end
    mc = 0;
    mr = 0;
  endtask

  // Monitor: one look per clock, just after the active edge.
  initial begin : monitor
    exp_t e;
    logic [2:0] last_col;
    logic [2:0] last_row;
    last_col = '0;
    last_row = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("reset_win_out", win_out, 72'h0);
        chk("reset_flags", {70'h0, win_valid, frame_done}, 72'h0);
        chk("reset_ctr", {66'h0, ctr_col, ctr_row}, 72'h0);
        last_col = '0;
        last_row = '0;
      end else begin
        if (!data_en)
          chk("idle_quiet", {70'h0, win_valid, frame_done}, 72'h0);
        if (win_valid) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 72'd1, 72'd0);
          end else begin
            e = exp_q.pop_front();
            chk("window_data", win_out, e.win);
            chk("window_ctr", {66'h0, ctr_col, ctr_row}, {66'h0, e.col, e.row});
            last_col = e.col;
            last_row = e.row;
          end
        end else begin
          chk("ctr_hold", {66'h0, ctr_col, ctr_row}, {66'h0, last_col, last_row});
        end
        if (frame_done) begin
          n_done++;
          if (done_q.size() == 0) chk("unexpected_frame_done", 72'd1, 72'd0);
          else void'(done_q.pop_front());
        end
        if (data_en) begin
          vlog[cur_idx] = win_valid;
          clog[cur_idx] = ctr_col;
          rlog[cur_idx] = ctr_row;
          wlog[cur_idx] = win_out;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_counts(input string name, input int v0, input int d0,
                              input int v_req, input int d_req);
    chk({name, "_windows"}, 72'(n_valid - v0), 72'(v_req));
    chk({name, "_frame_done"}, 72'(n_done - d0), 72'(d_req));
    chk({name, "_queue_drained"}, 72'(exp_q.size() + done_q.size()), 72'd0);
  endtask

  initial begin : stimulus
    int v0;
    int d0;
    rst         = 1'b0;
    data_en     = 1'b0;
    frame_start = 1'b0;
    row0_in     = '0;
    row1_in     = '0;
    row2_in     = '0;
    drive_reset(3);

    // Partial frame, then a mid-stream reset with data_en held high.
    for (int i = 0; i < 20; i++) drive_pix(1'b1, i == 0);
    drive_reset(2);

    // Counters must restart at (0,0) without frame_start.
    v0 = n_valid; d0 = n_done;
    for (int i = 0; i < 48; i++) drive_pix(1'b1, 1'b0);
    drive_pix(1'b0, 1'b0);
    drive_pix(1'b0, 1'b0);
    check_counts("post_reset_frame", v0, d0, 24, 1);

    // Continuous frame with frame_start on the first pixel.
    v0 = n_valid; d0 = n_done;
    for (int i = 0; i < 48; i++) drive_pix(1'b1, i == 0);
    drive_pix(1'b0, 1'b0);
    drive_pix(1'b0, 1'b0);
    check_counts("full_frame", v0, d0, 24, 1);

    // First valid window at pixel (2,2).
    chk("first_win_valid", 72'(vlog[18]), 72'd1);
    chk("first_win_ctr", {66'h0, clog[18], rlog[18]}, {66'h0, 3'd1, 3'd1});
    chk("first_win_p00", 72'(wlog[18][7:0]), 72'd0);
    chk("first_win_p11", 72'(wlog[18][39:32]), 72'd9);
    chk("first_win_p22", 72'(wlog[18][71:64]), 72'd18);
    chk("col1_row2_invalid", 72'(vlog[17]), 72'd0);

    // Line wrap around (7,2) -> (2,3).
    chk("wrap_7_2_valid", 72'(vlog[23]), 72'd1);
    chk("wrap_7_2_ctr", {66'h0, clog[23], rlog[23]}, {66'h0, 3'd6, 3'd1});
    chk("wrap_0_3_invalid", 72'(vlog[24]), 72'd0);
    chk("wrap_1_3_invalid", 72'(vlog[25]), 72'd0);
    chk("wrap_2_3_valid", 72'(vlog[26]), 72'd1);
    chk("wrap_2_3_ctr", {66'h0, clog[26], rlog[26]}, {66'h0, 3'd1, 3'd2});
    chk("last_pix_ctr", {66'h0, clog[47], rlog[47]}, {66'h0, 3'd6, 3'd4});

    // data_en toggling every cycle over a full frame.
    v0 = n_valid; d0 = n_done;
    for (int i = 0; i < 48; i++) begin
      drive_pix(1'b1, i == 0);
      drive_pix(1'b0, 1'b0);
    end
    drive_pix(1'b0, 1'b0);
    check_counts("toggle_frame", v0, d0, 24, 1);

    // frame_start arrives at (4,3) of a frame in progress.
    v0 = n_valid; d0 = n_done;
    for (int i = 0; i < 28; i++) drive_pix(1'b1, i == 0);
    drive_pix(1'b0, 1'b0);
    check_counts("abandoned_frame", v0, d0, 8, 0);
    v0 = n_valid; d0 = n_done;
    drive_pix(1'b1, 1'b1);
    chk("resync_position", 72'(cur_idx), 72'd0);
    for (int i = 0; i < 47; i++) drive_pix(1'b1, 1'b0);
    drive_pix(1'b0, 1'b0);
    drive_pix(1'b0, 1'b0);
    check_counts("resync_frame", v0, d0, 24, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
